sound_event_scheduler: RTL

// - Arbitrates one-cycle sound-event requests (lose, win, monster hit, wall hit) onto a single tone generator.
// - Plays a per-event melody from a constant note table, paced by an external tick.
// - Sits between game logic and the tone/ToneDecoder block, and drives EnableSound/frequency.
// - The live keypad tone is muxed downstream and is outside this block.

---
 rtl/sound_event_scheduler_pkg.sv | 55 +++++
 rtl/sound_event_scheduler_if.sv | 25 ++
 rtl/sound_event_scheduler_melody_rom.sv | 13 +
 rtl/sound_event_scheduler.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sound_event_scheduler_pkg.sv
// Shared types and constants for the sound event scheduler.
// Contents: sizing parameters, note entry type, FSM state enum, the constant
// melody table, the loop mask, and helpers for priority selection and
// end-of-melody lookahead.
package sound_event_scheduler_pkg;

  localparam int NUM_REQ = 4;
  localparam int NOTE_W  = 4;
  localparam int DUR_W   = 3;
  localparam int MEL_LEN = 4;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int IDX_W   = $clog2(MEL_LEN);

  typedef struct packed {
    logic [NOTE_W-1:0] freq;
    logic [DUR_W-1:0]  dur;
  } note_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAY      = 2'd1,
    ST_LOOP_HOLD = 2'd2
  } state_t;

  // Win and lose melodies repeat until stopped.
  localparam logic [NUM_REQ-1:0] LOOP_MASK = 4'b0011;

  // Row per requester; an entry with dur==0 terminates the melody.
  localparam note_t MELODY [NUM_REQ][MEL_LEN] = '{
    '{'{4'd9, 3'd2}, '{4'd7, 3'd2}, '{4'd5, 3'd2}, '{4'd0, 3'd0}},
    '{'{4'd5, 3'd2}, '{4'd3, 3'd2}, '{4'd1, 3'd2}, '{4'd0, 3'd0}},
    '{'{4'd6, 3'd2}, '{4'd0, 3'd0}, '{4'd0, 3'd0}, '{4'd0, 3'd0}},
    '{'{4'd4, 3'd1}, '{4'd0, 3'd0}, '{4'd0, 3'd0}, '{4'd0, 3'd0}}
  };

  // Lowest set index wins (index 0 is highest priority).
  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
      else      r = r;
    end
    return r;
  endfunction

  // True when advancing past note idx leaves the melody (wrap or end marker).
  function automatic logic melody_ends(input logic [ID_W-1:0] id,
                                       input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    nxt = idx + IDX_W'(1);
    return (idx == IDX_W'(MEL_LEN - 1)) || (MELODY[id][nxt].dur == '0);
  endfunction

endpackage

// File: rtl/sound_event_scheduler_if.sv
// Event/tone bus of the sound event scheduler.
// Game side (master) drives req/stop/tick; the scheduler (slave) drives
// EnableSound, frequency, busy, active_id and done.
interface sound_event_scheduler_if;
  import sound_event_scheduler_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               stop;
  logic               tick;
  logic               EnableSound;
  logic [NOTE_W-1:0]  frequency;
  logic               busy;
  logic [ID_W-1:0]    active_id;
  logic               done;

  modport master (
    output req, stop, tick,
    input  EnableSound, frequency, busy, active_id, done
  );

  modport slave (
    input  req, stop, tick,
    output EnableSound, frequency, busy, active_id, done
  );
endinterface

// File: rtl/sound_event_scheduler_melody_rom.sv
// Combinational melody lookup.
// Ports: i_id (requester), i_idx (note index) -> o_note {freq, dur}.
module sound_event_scheduler_melody_rom
  import sound_event_scheduler_pkg::*;
(
  input  logic [ID_W-1:0]  i_id,
  input  logic [IDX_W-1:0] i_idx,
  output note_t            o_note
);

  assign o_note = MELODY[i_id][i_idx];

endmodule

// File: rtl/sound_event_scheduler.sv
// Sound event scheduler: latches one-cycle event requests, grants them by
// fixed priority, and plays each requester's melody paced by tick.
// Ports: clk, reset (sync, active-high), bus (slave modport: req/stop/tick in;
// EnableSound/frequency/busy/active_id/done out, all registered).
module sound_event_scheduler
  import sound_event_scheduler_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  sound_event_scheduler_if.slave  bus
);

  state_t             r_state, w_state_nxt;
  logic [ID_W-1:0]    r_id, w_id_nxt, w_gid;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [DUR_W-1:0]   r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0] r_pend, w_pend_nxt, w_req_acc, w_clr;
  logic               w_any, w_preempt, w_end, w_grant, w_done_nxt, w_busy_nxt;
  note_t              r_note, w_note_nxt;

  assign w_any      = |r_pend;
  assign w_gid      = lowest_set(r_pend);
  assign w_end      = melody_ends(r_id, r_idx);
  // A looping melody can only be displaced by another looping one.
  assign w_preempt  = w_any && (w_gid < r_id) &&
                      ((r_state == ST_PLAY) || LOOP_MASK[w_gid]);
  assign w_busy_nxt = (w_state_nxt != ST_IDLE);

  // Outputs are registered from the entry being entered, so the ROM looks up
  // the next (id, idx) rather than the current one.
  sound_event_scheduler_melody_rom u_rom (
    .i_id   (w_id_nxt),
    .i_idx  (w_idx_nxt),
    .o_note (w_note_nxt)
  );

  // Request filter: while looping, lower-priority requests are discarded.
  always_comb begin
    w_req_acc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_acc[i] = bus.req[i] &&
                     !((r_state == ST_LOOP_HOLD) && (ID_W'(i) > r_id));
    end
  end

  // Next-state logic: grant, preemption, note timing and end of melody.
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_grant     = 1'b0;
    w_clr       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_grant     = 1'b1;
        else       w_state_nxt = ST_IDLE;
      end
      ST_PLAY, ST_LOOP_HOLD: begin
        // Preemption is checked first: it swallows a same-cycle tick and
        // suppresses done.
        if (w_preempt) begin
          w_grant = 1'b1;
        end else if (bus.tick && (r_cnt == r_note.dur - DUR_W'(1))) begin
          w_cnt_nxt = '0;
          if (!w_end) begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end else if (LOOP_MASK[r_id]) begin
            w_idx_nxt = '0;
          end else begin
            w_done_nxt = 1'b1;
            if (w_any) w_grant     = 1'b1;
            else       w_state_nxt = ST_IDLE;
          end
        end else if (bus.tick) begin
          w_cnt_nxt = r_cnt + DUR_W'(1);
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_grant) begin
      w_state_nxt   = LOOP_MASK[w_gid] ? ST_LOOP_HOLD : ST_PLAY;
      w_id_nxt      = w_gid;
      w_idx_nxt     = '0;
      w_cnt_nxt     = '0;
      w_clr[w_gid]  = 1'b1;
    end else begin
      w_clr = '0;
    end
    w_pend_nxt = (r_pend & ~w_clr) | w_req_acc;
  end

  // State and output registers; stop clears everything like reset does.
  always_ff @(posedge clk) begin
    if (reset || bus.stop) begin
      r_state         <= ST_IDLE;
      r_id            <= '0;
      r_idx           <= '0;
      r_cnt           <= '0;
      r_pend          <= '0;
      r_note          <= '0;
      bus.EnableSound <= 1'b0;
      bus.frequency   <= '0;
      bus.busy        <= 1'b0;
      bus.active_id   <= '0;
      bus.done        <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_id            <= w_id_nxt;
      r_idx           <= w_idx_nxt;
      r_cnt           <= w_cnt_nxt;
      r_pend          <= w_pend_nxt;
      r_note          <= w_note_nxt;
      bus.EnableSound <= w_busy_nxt && (w_note_nxt.freq != '0);
      bus.frequency   <= w_busy_nxt ? w_note_nxt.freq : '0;
      bus.busy        <= w_busy_nxt;
      bus.active_id   <= w_id_nxt;
      bus.done        <= w_done_nxt;
    end
  end

endmodule
